// File: rtl/dpram_port_master_pkg.sv
// rtl/dpram_port_master_pkg.sv - shared encodings and defaults for the dpram port master
package dpram_port_master_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_RD_LAT     = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/dpram_rsp_fifo.sv
// rtl/dpram_rsp_fifo.sv - in-order read response buffer, head shown whenever non-empty
module dpram_rsp_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_rdata,
    input  logic              push_err,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_rdata,
    output logic              head_err,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  err_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Wrap explicitly so non power-of-two depths still cycle through every entry.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    assign do_push    = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head_rdata = head_valid ? data_q[rd_ptr] : '0;
    assign head_err   = head_valid && err_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_q[wr_ptr] <= push_rdata;
            err_q[wr_ptr]  <= push_err;
        end
    end

endmodule

// File: rtl/dpram_port_master.sv
// rtl/dpram_port_master.sv - drives one RAM port: zero-fill at start, then ordered read/write requests
module dpram_port_master
    import dpram_port_master_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              init_done,
    output logic [7:0]        err_cnt
);

    localparam int                FCNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [RD_LAT-1:0] sr_v;
    logic [RD_LAT-1:0] sr_e;
    logic [RD_LAT-1:0] sr_v_nxt;
    logic [RD_LAT-1:0] sr_e_nxt;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic              mem_we_q;
    logic              in_range;
    logic              accept;
    logic              acc_rd;
    logic              acc_mem;
    logic              busy_nxt;
    int                inflight;
    logic              push;
    logic [DATA_W-1:0] push_rdata;
    logic              push_err;
    logic              pop;
    logic [FCNT_W-1:0] fifo_count;

    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 32'(sr_v[i]);
        end
    end

    // Writes wait for the read pipe to drain so a response never sees a later write.
    always_comb begin
        in_range = ({1'b0, req_addr} < DEPTH_C);
        if (state == ST_INIT) begin
            req_ready = 1'b0;
        end else if (req_we == MEM_WRITE) begin
            req_ready = (inflight == 0);
        end else begin
            req_ready = ((inflight + 32'(fifo_count)) < FIFO_DEPTH);
        end
        accept  = req_valid && req_ready;
        acc_rd  = accept && (req_we == MEM_READ);
        acc_mem = accept && in_range;
        if (acc_mem) begin
            mem_addr = req_addr;
            mem_din  = req_wdata;
            mem_we   = (req_we == MEM_WRITE);
        end else begin
            mem_addr = mem_addr_q;
            mem_din  = mem_din_q;
            mem_we   = mem_we_q;
        end
    end

    assign sr_v_nxt   = (sr_v << 1) | RD_LAT'(acc_rd);
    assign sr_e_nxt   = (sr_e << 1) | RD_LAT'(acc_rd && !in_range);
    assign push       = sr_v[RD_LAT-1];
    assign push_err   = sr_e[RD_LAT-1];
    assign push_rdata = push_err ? '0 : mem_dout;
    assign pop        = rsp_valid && rsp_ready;
    assign busy_nxt   = (sr_v_nxt != '0) ||
                        ((32'(fifo_count) + 32'(push) - 32'(pop)) != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            sr_v       <= '0;
            sr_e       <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            init_done  <= 1'b0;
            err_cnt    <= 8'h00;
        end else begin
            case (state)
                ST_INIT: begin
                    mem_din_q <= '0;
                    if (!mem_we_q) begin
                        mem_we_q   <= MEM_WRITE;
                        mem_addr_q <= '0;
                    end else if (mem_addr_q == LAST_ADDR) begin
                        mem_we_q  <= MEM_READ;
                        init_done <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        mem_addr_q <= mem_addr_q + 1'b1;
                    end
                end
                default: begin
                    sr_v <= sr_v_nxt;
                    sr_e <= sr_e_nxt;
                    if (acc_mem) begin
                        mem_addr_q <= req_addr;
                        mem_din_q  <= req_wdata;
                    end
                    if (accept && !in_range && (err_cnt != 8'hFF)) begin
                        err_cnt <= err_cnt + 8'h01;
                    end
                    state <= busy_nxt ? ST_ACTIVE : ST_IDLE;
                end
            endcase
        end
    end

    dpram_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (FCNT_W)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_rdata (push_rdata),
        .push_err   (push_err),
        .pop        (pop),
        .head_valid (rsp_valid),
        .head_rdata (rsp_rdata),
        .head_err   (rsp_err),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_dpram_port_master.sv
// tb/tb_dpram_port_master.sv - directed and random checks of dpram_port_master against a queue model
module tb_dpram_port_master;

    localparam int RD_LAT = 2;
    localparam int FDEPTH = 4;
    localparam int NWORDS = 8;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_we;
    logic [7:0] mem_dout;
    logic       init_done;
    logic [7:0] err_cnt;

    dpram_port_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout),
        .init_done (init_done),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with a two-stage registered read path
    logic [7:0] ram [256];
    logic [7:0] rq1;
    logic [7:0] rq2;
    int         bad_wr = 0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        if (mem_we && mem_addr >= 8'(NWORDS)) bad_wr <= bad_wr + 1;
        rq1 <= ram[mem_addr];
        rq2 <= rq1;
    end
    assign mem_dout = rq2;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] model_mem [NWORDS];
    int         exp_err = 0;
    int         now = 0;
    bit         model_on = 0;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Model: a request is in flight for RD_LAT cycles after acceptance, then sits buffered.
    task automatic at_neg();
        exp_t e;
        bit   busy;
        bit   oor;
        @(negedge clk);
        now++;
        if (model_on) begin
            busy = (q.size() > 0) && ((now - q[q.size()-1].cyc) <= RD_LAT);
            chk("m_req_ready", 32'(req_ready), req_we ? 32'(!busy) : 32'(q.size() < FDEPTH));
            chk("m_rsp_valid", 32'(rsp_valid), 32'((q.size() > 0) && ((now - q[0].cyc) > RD_LAT)));
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("m_rsp_spurious", 32'(rsp_valid), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("m_rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                    chk("m_rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            if (req_valid && req_ready) begin
                oor = (req_addr >= 8'(NWORDS));
                if (oor && exp_err < 255) exp_err++;
                if (req_we) begin
                    if (!oor) model_mem[req_addr[2:0]] = req_wdata;
                end else begin
                    e.data = oor ? 8'h00 : model_mem[req_addr[2:0]];
                    e.err  = oor;
                    e.cyc  = now;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            at_neg();
            at_pos();
        end
        at_neg();
        chk("drain_q", 32'(q.size()), 32'(0));
        chk("drain_rsp_valid", 32'(rsp_valid), 32'(0));
        at_pos();
    endtask

    task automatic check_init();
        at_neg();
        chk("init_pre_we", 32'(mem_we), 32'(0));
        at_pos();
        for (int i = 0; i < NWORDS; i++) begin
            at_neg();
            chk("init_we", 32'(mem_we), 32'(1));
            chk("init_addr", 32'(mem_addr), 32'(i));
            chk("init_din", 32'(mem_din), 32'(0));
            chk("init_ready", 32'(req_ready), 32'(0));
            chk("init_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("init_not_done", 32'(init_done), 32'(0));
            at_pos();
        end
        at_neg();
        chk("init_done", 32'(init_done), 32'(1));
        chk("init_ready_up", 32'(req_ready), 32'(1));
        chk("init_we_off", 32'(mem_we), 32'(0));
        at_pos();
        for (int i = 0; i < NWORDS; i++) model_mem[i] = 8'h00;
        q.delete();
        exp_err  = 0;
        model_on = 1;
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        req_addr = 8'h00;
        req_wdata = 8'h00;
        idle();
        #1;
        repeat (3) begin
            at_neg();
            chk("rst_init_done", 32'(init_done), 32'(0));
            chk("rst_req_ready", 32'(req_ready), 32'(0));
            chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
            chk("rst_rsp_err", 32'(rsp_err), 32'(0));
            chk("rst_mem_we", 32'(mem_we), 32'(0));
            chk("rst_mem_addr", 32'(mem_addr), 32'(0));
            chk("rst_mem_din", 32'(mem_din), 32'(0));
            chk("rst_err_cnt", 32'(err_cnt), 32'(0));
            at_pos();
        end
        rst_n = 1'b1;
        check_init();

        // write then read back with RD_LAT latency
        drive(1'b1, 8'd3, 8'h5A);
        at_neg();
        chk("wr_ready", 32'(req_ready), 32'(1));
        chk("wr_mem_we", 32'(mem_we), 32'(1));
        chk("wr_mem_addr", 32'(mem_addr), 32'(3));
        chk("wr_mem_din", 32'(mem_din), 32'h5A);
        at_pos();
        rsp_ready = 1'b1;
        drive(1'b0, 8'd3, 8'h00);
        at_neg();
        chk("rd_mem_we", 32'(mem_we), 32'(0));
        chk("rd_mem_addr", 32'(mem_addr), 32'(3));
        at_pos();
        idle();
        at_neg();
        chk("rd_lat1_valid", 32'(rsp_valid), 32'(0));
        at_pos();
        at_neg();
        chk("rd_lat2_valid", 32'(rsp_valid), 32'(0));
        chk("rd_addr_hold", 32'(mem_addr), 32'(3));
        at_pos();
        at_neg();
        chk("rd_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("rd_rsp_rdata", 32'(rsp_rdata), 32'h5A);
        chk("rd_rsp_err", 32'(rsp_err), 32'(0));
        at_pos();

        for (int a = 0; a < NWORDS; a++) begin
            drive(1'b1, 8'(a), 8'($urandom));
            at_neg();
            at_pos();
        end

        // four reads fill the buffer, the fifth is held off
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'(i), 8'h00);
            at_neg();
            chk("fill_ready", 32'(req_ready), 32'(1));
            at_pos();
        end
        drive(1'b0, 8'd4, 8'h00);
        at_neg();
        chk("fill_5th_blocked", 32'(req_ready), 32'(0));
        at_pos();
        idle();
        repeat (3) begin
            at_neg();
            at_pos();
        end
        at_neg();
        chk("fill_head_valid", 32'(rsp_valid), 32'(1));
        chk("fill_head_data", 32'(rsp_rdata), 32'(model_mem[0]));
        at_pos();
        drain();

        // out-of-range read and write
        rsp_ready = 1'b0;
        drive(1'b0, 8'd9, 8'h00);
        at_neg();
        chk("oor_rd_ready", 32'(req_ready), 32'(1));
        chk("oor_rd_addr_hold", 32'(mem_addr), 32'(3));
        at_pos();
        idle();
        repeat (2) begin
            at_neg();
            at_pos();
        end
        at_neg();
        chk("oor_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("oor_rsp_err", 32'(rsp_err), 32'(1));
        chk("oor_rsp_rdata", 32'(rsp_rdata), 32'(0));
        at_pos();
        drain();
        drive(1'b1, 8'd12, 8'hAA);
        at_neg();
        chk("oor_wr_ready", 32'(req_ready), 32'(1));
        chk("oor_wr_we", 32'(mem_we), 32'(0));
        at_pos();
        idle();
        at_neg();
        chk("oor_err_cnt", 32'(err_cnt), 32'(2));
        chk("oor_no_ram_wr", 32'(bad_wr), 32'(0));
        at_pos();

        // write behind a read waits for capture
        rsp_ready = 1'b1;
        drive(1'b0, 8'd5, 8'h00);
        at_neg();
        at_pos();
        drive(1'b1, 8'd6, 8'h3C);
        at_neg();
        chk("wr_wait1_ready", 32'(req_ready), 32'(0));
        chk("wr_wait1_we", 32'(mem_we), 32'(0));
        at_pos();
        at_neg();
        chk("wr_wait2_ready", 32'(req_ready), 32'(0));
        at_pos();
        at_neg();
        chk("wr_go_ready", 32'(req_ready), 32'(1));
        chk("wr_go_we", 32'(mem_we), 32'(1));
        chk("wr_go_addr", 32'(mem_addr), 32'(6));
        at_pos();
        drive(1'b0, 8'd6, 8'h00);
        at_neg();
        at_pos();
        idle();
        drain();

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = ($urandom_range(0, 2) == 0);
            req_addr  = 8'($urandom_range(0, 11));
            req_wdata = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            at_neg();
            at_pos();
        end
        idle();
        drain();
        at_neg();
        chk("rand_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("rand_no_ram_wr", 32'(bad_wr), 32'(0));
        at_pos();

        // err_cnt saturation
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 8'(8 + (i % 4)), 8'h00);
            at_neg();
            at_pos();
        end
        idle();
        at_neg();
        chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
        at_pos();

        // reset with two reads in flight
        rsp_ready = 1'b0;
        drive(1'b0, 8'd1, 8'h00);
        at_neg();
        at_pos();
        drive(1'b0, 8'd2, 8'h00);
        at_neg();
        at_pos();
        idle();
        rst_n = 1'b0;
        model_on = 0;
        q.delete();
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("mid_rst_init_done", 32'(init_done), 32'(0));
        chk("mid_rst_ready", 32'(req_ready), 32'(0));
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'(0));
        chk("mid_rst_mem_we", 32'(mem_we), 32'(0));
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'(0));
        at_neg();
        at_pos();
        at_neg();
        chk("mid_rst_hold_valid", 32'(rsp_valid), 32'(0));
        at_pos();
        rst_n = 1'b1;
        check_init();
        at_neg();
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        at_pos();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpram_port_master.md
DPRAM_PORT_MASTER -- requirements
Module: dpram_port_master

Interface
REQ-001 The block SHALL have one clock, clk; reset, rst_n, SHALL be asynchronous and active-low.
REQ-002 Parameter ADDR_W, default 8, SHALL set the address width.
REQ-003 Parameter DATA_W, default 8, SHALL set the data width.
REQ-004 Parameter DEPTH, default 8, SHALL set the number of implemented RAM words.
REQ-005 Parameter RD_LAT, default 2, SHALL set the RAM read latency in clk edges.
REQ-006 Parameter FIFO_DEPTH, default 4, SHALL set the number of response buffer entries.
REQ-007 clk  in  1  clock for all logic and the driven RAM port.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 req_valid / req_ready  in / out  1 / 1  request handshake; a transfer occurs on a clk edge when both are high.
REQ-010 req_we / req_addr / req_wdata  in  1 / ADDR_W / DATA_W  1 = write, 0 = read; address; write data.
REQ-011 rsp_valid / rsp_ready  out / in  1 / 1  read-response handshake.
REQ-012 rsp_rdata / rsp_err  out  DATA_W / 1  read data; out-of-range flag.
REQ-013 mem_addr / mem_din / mem_we  out  ADDR_W / DATA_W / 1  drive one RAM port: address, write data, and write enable (1 = WRITE).
REQ-014 mem_dout  in  DATA_W  RAM read data, valid RD_LAT edges after mem_we=0 with mem_addr presented.
REQ-015 init_done / err_cnt  out  1 / 8  init complete; saturating count of out-of-range requests.

Function
REQ-016 The FSM SHALL have states INIT, IDLE, and ACTIVE; INIT SHALL write 0x00 to addresses 0..DEPTH-1, one per cycle, with mem_we=1.
REQ-017 INIT->IDLE SHALL occur after address DEPTH-1 is written; init_done SHALL rise on the cycle IDLE is entered and stay high until reset.
REQ-018 req_ready SHALL be 0 in INIT.
REQ-019 Outside INIT, a write SHALL be accepted only when no read is in flight.
REQ-020 A read SHALL be accepted only when in-flight reads plus FIFO occupancy is less than FIFO_DEPTH.
REQ-021 An accepted in-range request SHALL drive mem_addr, mem_we, and mem_din combinationally in the cycle of acceptance.
REQ-022 With no accepted request, mem_we SHALL be 0 and mem_addr SHALL hold its last value.
REQ-023 Reads SHALL pipeline back-to-back at one per cycle, tracked by an RD_LAT-deep valid/err shift register.
REQ-024 mem_dout SHALL be captured into the FIFO when a read exits the shift register, exactly RD_LAT edges after acceptance.
REQ-025 A read with req_addr >= DEPTH SHALL NOT access the RAM, SHALL follow the same RD_LAT timing, and SHALL produce rsp_err=1 with rsp_rdata=0x00.
REQ-026 A write with req_addr >= DEPTH SHALL be accepted and dropped with mem_we=0.
REQ-027 Every out-of-range request SHALL increment err_cnt, saturating at 0xFF.
REQ-028 Responses SHALL be returned in request order; the FIFO head SHALL be presented on rsp_* with rsp_valid=1 whenever the FIFO is non-empty.
REQ-029 A FIFO push and pop in the same cycle SHALL leave the occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 ACTIVE SHALL be the state while any read is in flight or the FIFO is non-empty; otherwise the FSM SHALL be in IDLE.

Reset
REQ-031 Reset assertion SHALL immediately force the following values: state=INIT, init_done=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_din=0, err_cnt=0; it SHALL also empty the FIFO and clear the shift register.
REQ-032 Reset asserted mid-operation SHALL discard in-flight reads and buffered responses; INIT SHALL restart at address 0 after deassertion.

Structure
REQ-033 A shared package SHALL hold the state encoding, READ/WRITE constants, and the default parameter values.
REQ-034 The response FIFO SHALL be the single sub-module, dpram_rsp_fifo.

Verification
REQ-035 Release reset -> mem_we=1 for 8 cycles at addresses 0..7 with data 0x00, then init_done=1 and req_ready=1.
REQ-036 Write 0x5A to addr 3, then read addr 3 with rsp_ready=1 -> rsp_valid=1 with rsp_rdata=0x5A and rsp_err=0, 2 cycles after read acceptance.
REQ-037 Reads of addrs 0..3 on consecutive cycles with rsp_ready=0 -> 4 accepted, req_ready=0 on the 5th; after rsp_ready=1 -> responses returned in order 0, 1, 2, 3.
REQ-038 Read addr 9, then write to addr 12 -> rsp_err=1 with rsp_rdata=0x00, no RAM write occurs, and err_cnt=2.
REQ-039 Write request presented 1 cycle after a read -> req_ready=0 until the read's data is captured, then the write is accepted.
REQ-040 rst_n pulsed low with 2 reads in flight -> rsp_valid=0 immediately, the FIFO is empty, and INIT restarts from address 0.
